// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential 8x8->16 unsigned multiplier built on repeated addition.
// It is the only master of an external alu. The alu result (alu_sout) is combinational.
// The alu flags (alu_cflag, alu_zflag) are registered on an alu_ena edge, so they are
// only consulted in the cycle after an issuing state.
// Optional feature: define ALU_MUL_SWAP_EN to add CMP/SWP states. These make the loop
// count min(a,b) instead of b.
module alu_mul_seq (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [1:0]  alu_ctrl,
  output logic [7:0]  alu_ain,
  output logic [7:0]  alu_bin,
  output logic        alu_ena,
  input  logic [7:0]  alu_sout,
  input  logic        alu_cflag,
  input  logic        alu_zflag
);

  localparam logic [1:0] CtrlInc = 2'b00;
  localparam logic [1:0] CtrlDec = 2'b01;
  localparam logic [1:0] CtrlAdd = 2'b10;
  localparam logic [1:0] CtrlSub = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
`ifdef ALU_MUL_SWAP_EN
    StCmp,
    StSwp,
`endif
    StTest,
    StChkz,
    StAddlo,
    StAddc,
    StInchi,
    StDec,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  acc_hi_q, acc_hi_d;
  logic [7:0]  acc_lo_q, acc_lo_d;
  logic [15:0] product_q, product_d;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flag tests happen one cycle after the issuing state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
`ifdef ALU_MUL_SWAP_EN
          state_d = StCmp;
`else
          state_d = StTest;
`endif
        end
      end
`ifdef ALU_MUL_SWAP_EN
      StCmp:   state_d = StSwp;
      StSwp:   state_d = StTest;
`endif
      StTest:  state_d = StChkz;
      StChkz:  state_d = alu_zflag ? StDone : StAddlo;
      StAddlo: state_d = StAddc;
      StAddc:  state_d = alu_cflag ? StInchi : StDec;
      StInchi: state_d = StDec;
      StDec:   state_d = StChkz;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and alu operand steering, decoded from the current state.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    alu_ctrl = CtrlInc;
    alu_ain  = 8'h00;
    alu_bin  = 8'h00;
    alu_ena  = 1'b0;
    case (state_q)
`ifdef ALU_MUL_SWAP_EN
      StCmp: begin
        // Borrow out of mcand - cnt means mcand < cnt.
        alu_ctrl = CtrlSub;
        alu_ain  = mcand_q;
        alu_bin  = cnt_q;
        alu_ena  = 1'b1;
      end
`endif
      StTest: begin
        // cnt + 0 sets zflag exactly when cnt == 0.
        alu_ctrl = CtrlAdd;
        alu_ain  = cnt_q;
        alu_ena  = 1'b1;
      end
      StAddlo: begin
        alu_ctrl = CtrlAdd;
        alu_ain  = acc_lo_q;
        alu_bin  = mcand_q;
        alu_ena  = 1'b1;
      end
      StInchi: begin
        alu_ctrl = CtrlInc;
        alu_ain  = acc_hi_q;
        alu_ena  = 1'b1;
      end
      StDec: begin
        alu_ctrl = CtrlDec;
        alu_ain  = cnt_q;
        alu_ena  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: operand capture, accumulator updates and product latch.
  always_comb begin
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = a;
          cnt_d    = b;
          acc_hi_d = 8'h00;
          acc_lo_d = 8'h00;
        end
      end
`ifdef ALU_MUL_SWAP_EN
      StSwp: begin
        if (alu_cflag) begin
          mcand_d = cnt_q;
          cnt_d   = mcand_q;
        end
      end
`endif
      StChkz: begin
        // Latch on entry to DONE so product is valid alongside the done pulse.
        if (alu_zflag) begin
          product_d = {acc_hi_q, acc_lo_q};
        end
      end
      StAddlo: acc_lo_d = alu_sout;
      StInchi: acc_hi_d = alu_sout;
      StDec:   cnt_d    = alu_sout;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mcand_q   <= 8'h00;
      cnt_q     <= 8'h00;
      acc_hi_q  <= 8'h00;
      acc_lo_q  <= 8'h00;
      product_q <= 16'h0000;
    end else begin
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule
